uart_msg_arbiter: RTL and testbench
===================================

UART_MSG_ARBITER -- requirements
Module: uart_msg_arbiter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  N_REQ, 4, number of emulator requesters; legal range 2..8.
  TIMEOUT_CYC, 1600, stall cycles before a granted message is aborted; legal range 2..65535.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; 160 MHz logic clock.
  reset_n  in  1  asynchronous, active-low reset.
  req_valid  in  N_REQ  per-requester byte valid.
  req_data  in  8*N_REQ  per-requester byte; slice i = [8i+7:8i].
  req_last  in  N_REQ  marks the final byte of a message.
  req_ready  out  N_REQ  per-requester byte accept.
  tx_data  out  8  byte to the shared UART transmitter.
  tx_valid  out  1  tx_data valid.
  tx_ready  in  1  transmitter accepts the byte.
  grant_id  out  3  index of the current owner.
  busy  out  1  high in any state other than IDLE.
  timeout_pulse  out  1  one-cycle strobe on message abort.

Function
REQ-003 SHALL implement the FSM states IDLE, HDR, DATA and ABORT.
REQ-004 A byte SHALL transfer on any rising clk edge with valid=1 and ready=1 (tx and req sides alike).
REQ-005 IDLE: if any req_valid=1, SHALL pick the lowest index at or after rr_ptr, scanning cyclically modulo N_REQ.
REQ-006 On that pick, at the next edge it SHALL load grant_id and enter HDR.
REQ-007 IDLE with no req_valid SHALL stay in IDLE with tx_valid=0.
REQ-008 Latency: req_valid rising in IDLE at cycle n SHALL give tx_valid=1 with the header at cycle n+1.
REQ-009 HDR: tx_valid=1, tx_data=8'hA0 | grant_id, req_ready=0.
REQ-010 HDR: on tx handshake SHALL enter DATA, whatever the owner's req_valid.
REQ-011 DATA: tx_valid=req_valid[g], tx_data=req_data slice g, req_ready[g]=tx_ready; combinational, zero added latency (g = grant_id).
REQ-012 req_ready of every non-owner SHALL be 0 in every state.
REQ-013 DATA: handshake with req_last[g]=1 SHALL enter IDLE and set rr_ptr=(g+1) mod N_REQ.
REQ-014 DATA: a 16-bit stall counter SHALL increment each cycle with req_valid[g]=0.
REQ-015 The stall counter SHALL clear on every data handshake and on every entry to DATA.
REQ-016 DATA: when the stall counter reaches TIMEOUT_CYC-1 with req_valid[g] still 0, the FSM SHALL enter ABORT at the next edge.
REQ-017 On ABORT entry, timeout_pulse SHALL be 1 for exactly that one cycle.
REQ-018 ABORT: tx_valid=1, tx_data=8'hFF, req_ready=0.
REQ-019 ABORT: on tx handshake SHALL enter IDLE and set rr_ptr=(g+1) mod N_REQ.
REQ-020 While tx_valid=1 and tx_ready=0 in HDR or ABORT, tx_data SHALL stay stable.
REQ-021 In DATA, tx_data stability SHALL rely on the requester holding its byte.
REQ-022 Owner req_valid and req_last SHALL be sampled only on a handshake; req_last without req_valid SHALL be ignored.
REQ-023 A message of one byte (valid and last in the same beat) SHALL send header, byte, then return to IDLE.
REQ-024 Requests from non-owners SHALL never pre-empt an active message; they wait, with req_ready=0.
REQ-025 busy SHALL be 0 only in IDLE.
REQ-026 In IDLE, tx_data SHALL be 8'h00.

Reset
REQ-027 reset_n=0 SHALL act immediately, with no clock needed.
REQ-028 While reset_n=0: state=IDLE, rr_ptr=0, grant_id=0, stall counter=0.
REQ-029 While reset_n=0: tx_valid=0, tx_data=8'h00, req_ready=0, busy=0, timeout_pulse=0.
REQ-030 A message in flight when reset asserts SHALL be dropped with no abort byte.
REQ-031 The first grant after reset release SHALL scan from index 0.

Verification
REQ-032 Req0 sends {8'h11, 8'h22 last}, tx_ready=1 -> tx stream A0,11,22; busy low the cycle after 22; rr_ptr=1.
REQ-033 Req0 and req2 both valid in IDLE after reset -> req0 message first (A0 …), then req2 (A2 …).
REQ-034 Two back-to-back messages from req1, with req3 pending -> A1-message, A3-message, then A1-message.
REQ-035 tx_ready=0 for 5 cycles during HDR of req2 -> tx_data stays A2 and tx_valid=1 for all 5; req_ready=0.
REQ-036 TIMEOUT_CYC=8; req1 sends 8'h55 (no last) then drops valid -> 8 stall cycles, then timeout_pulse for 1 cycle, tx sends FF, FSM returns to IDLE, next grant scans from 2.
REQ-037 reset_n pulsed low mid-DATA of req3 -> outputs zero at once; after release, req3 still valid -> header A3 restarts the message.

Source files
------------

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter that lets N_REQ emulator requesters share one UART transmitter.
// Each granted message is framed by a header byte (A0|id); a stalled message is aborted with FF.
module uart_msg_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1600
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_ABORT
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  LAST_IDX    = 3'(N_REQ - 1);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [2:0]  r_grant, w_grant_nxt;
    logic [15:0] r_stall, w_stall_nxt;
    logic        r_timeout_pulse, w_timeout_nxt;

    logic        w_own_valid;
    logic        w_own_last;
    logic [7:0]  w_own_data;
    logic        w_found_hi, w_found_lo;
    logic [2:0]  w_pick_hi, w_pick_lo, w_pick;
    logic [2:0]  w_next_ptr;

    // Owner-side view of the request bus, selected by the current grant.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == 3'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[8*i +: 8];
            end
        end
    end

    // Cyclic priority from rr_ptr: prefer the lowest valid index at or above the
    // pointer, otherwise wrap to the lowest valid index overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_pick_hi  = 3'd0;
        w_pick_lo  = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_found_lo = 1'b1;
                w_pick_lo  = 3'(i);
                if (3'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_pick_hi  = 3'(i);
                end
            end
        end
    end

    assign w_pick     = w_found_hi ? w_pick_hi : w_pick_lo;
    assign w_next_ptr = (r_grant == LAST_IDX) ? 3'd0 : r_grant + 3'd1;

    // NOTE: every output of this block gets a default before the case statement,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_stall_nxt   = r_stall;
        w_timeout_nxt = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        req_ready     = '0;

        case (r_state)
            ST_IDLE: begin
                w_stall_nxt = 16'd0;
                if (w_found_lo) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ST_HDR;
                end
            end

            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = 8'hA0 | {5'd0, r_grant};
                if (tx_ready) begin
                    w_stall_nxt = 16'd0;
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                tx_valid = w_own_valid;
                tx_data  = w_own_data;
                for (int i = 0; i < N_REQ; i++) begin
                    req_ready[i] = tx_ready && (r_grant == 3'(i));
                end
                if (w_own_valid) begin
                    // Waiting on tx_ready is not a requester stall.
                    if (tx_ready) begin
                        w_stall_nxt = 16'd0;
                        if (w_own_last) begin
                            w_rr_ptr_nxt = w_next_ptr;
                            w_state_nxt  = ST_IDLE;
                        end
                    end
                end else if (r_stall == STALL_LIMIT) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_ABORT;
                end else begin
                    w_stall_nxt = r_stall + 16'd1;
                end
            end

            ST_ABORT: begin
                tx_valid = 1'b1;
                tx_data  = 8'hFF;
                if (tx_ready) begin
                    w_rr_ptr_nxt = w_next_ptr;
                    w_state_nxt  = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= 3'd0;
            r_grant         <= 3'd0;
            r_stall         <= 16'd0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_grant         <= w_grant_nxt;
            r_stall         <= w_stall_nxt;
            r_timeout_pulse <= w_timeout_nxt;
        end
    end

    assign grant_id      = r_grant;
    assign busy          = (r_state != ST_IDLE);
    assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Self-checking bench for uart_msg_arbiter: arbitration vector table, directed corner
// sequences, and randomized traffic scored against a message-level round-robin model.
module tb_uart_msg_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic [2:0]     grant_id;
    logic           busy;
    logic           timeout_pulse;

    uart_msg_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
        req_valid[r]       = v;
        req_data[8*r +: 8] = d;
        req_last[r]        = l;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_txv"},   32'(tx_valid), 0);
        check({tag, "_txd"},   32'(tx_data), 0);
        check({tag, "_rdy"},   32'(req_ready), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_pulse"}, 32'(timeout_pulse), 0);
        check({tag, "_gnt"},   32'(grant_id), 0);
    endtask

    // Leaves the bench at a negedge with reset released and inputs cleared.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        settle();
        check_outputs_zero("rst");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sends a one-byte message from IDLE with tx_ready held high; ends back in IDLE.
    task automatic send_one(input int r, input logic [7:0] b);
        logic [7:0] hdr;
        hdr = 8'hA0 | 8'(r);
        set_req(r, 1'b1, b, 1'b1);
        tx_ready = 1'b1;
        settle();
        check("one_idle_txv", 32'(tx_valid), 0);
        cyc();
        check("one_hdr", 32'(tx_data), 32'(hdr));
        cyc();
        check("one_byte", 32'(tx_data), 32'(b));
        cyc();
        check("one_idle_busy", 32'(busy), 0);
        set_req(r, 1'b0, 8'h00, 1'b0);
    endtask

    typedef struct {
        logic       has_prior;
        int         prior;
        logic [3:0] pattern;
        int         exp_grant;
    } arb_vec_t;

    arb_vec_t vecs[8];

    // Randomized traffic storage: per-requester byte streams and reference model.
    logic [7:0] sbyte [N][16];
    logic       slast [N][16];
    int         scount [N];
    int         spos [N];
    int         gap [N];
    int         msg_cnt [N];
    int         msg_len [N][4];
    logic       hs [N];
    logic [7:0] exp_q [$];

    task automatic build_random_traffic();
        int mi [N];
        int bp [N];
        int ptr;
        int remaining;
        int idx;
        remaining = 0;
        for (int r = 0; r < N; r++) begin
            scount[r]  = 0;
            msg_cnt[r] = $urandom_range(1, 4);
            for (int m = 0; m < msg_cnt[r]; m++) begin
                msg_len[r][m] = $urandom_range(1, 4);
                for (int b = 0; b < msg_len[r][m]; b++) begin
                    sbyte[r][scount[r]] = 8'($urandom);
                    slast[r][scount[r]] = (b == msg_len[r][m] - 1);
                    scount[r]++;
                end
            end
            remaining += msg_cnt[r];
            mi[r] = 0;
            bp[r] = 0;
        end
        // Every requester with messages left is always requesting when the
        // arbiter is idle, so grants follow plain round-robin over them.
        exp_q.delete();
        ptr = 0;
        while (remaining > 0) begin
            idx = -1;
            for (int k = 0; k < N; k++) begin
                if (idx < 0 && mi[(ptr + k) % N] < msg_cnt[(ptr + k) % N])
                    idx = (ptr + k) % N;
            end
            exp_q.push_back(8'hA0 | 8'(idx));
            for (int b = 0; b < msg_len[idx][mi[idx]]; b++) begin
                exp_q.push_back(sbyte[idx][bp[idx]]);
                bp[idx]++;
            end
            mi[idx]++;
            remaining--;
            ptr = (idx + 1) % N;
        end
    endtask

    task automatic random_round();
        int   budget;
        logic was_last;
        do_reset();
        build_random_traffic();
        for (int r = 0; r < N; r++) begin
            spos[r] = 0;
            gap[r]  = 0;
            hs[r]   = 1'b0;
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 5000) begin
            for (int r = 0; r < N; r++) begin
                if (hs[r]) begin
                    was_last = slast[r][spos[r]];
                    spos[r]++;
                    gap[r] = was_last ? 0 : $urandom_range(0, 3);
                end else if (gap[r] > 0) begin
                    gap[r]--;
                end
            end
            for (int r = 0; r < N; r++) begin
                if (spos[r] < scount[r] && gap[r] == 0)
                    set_req(r, 1'b1, sbyte[r][spos[r]], slast[r][spos[r]]);
                else
                    set_req(r, 1'b0, 8'($urandom), 1'($urandom));
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            settle();
            if (tx_valid && tx_ready)
                check("rand_tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            check("rand_nonowner_ready", 32'(req_ready & ~(4'b0001 << grant_id)), 0);
            check("rand_no_timeout", 32'(timeout_pulse), 0);
            for (int r = 0; r < N; r++)
                hs[r] = req_valid[r] & req_ready[r];
            cyc();
            budget++;
        end
        check("rand_stream_done", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();

        vecs[0] = '{1'b0, 0, 4'b0101, 0};
        vecs[1] = '{1'b0, 0, 4'b1000, 3};
        vecs[2] = '{1'b0, 0, 4'b0110, 1};
        vecs[3] = '{1'b1, 0, 4'b0001, 0};
        vecs[4] = '{1'b1, 0, 4'b0101, 2};
        vecs[5] = '{1'b1, 2, 4'b0011, 0};
        vecs[6] = '{1'b1, 3, 4'b1100, 2};
        vecs[7] = '{1'b1, 1, 4'b1111, 2};

        // Arbitration table: optional one-byte message to move rr_ptr, then a request pattern.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].has_prior)
                send_one(vecs[i].prior, 8'(8'h5A + i));
            for (int r = 0; r < N; r++)
                set_req(r, vecs[i].pattern[r], 8'(8'h10 + r), 1'b1);
            tx_ready = 1'b1;
            settle();
            check("vec_idle_txv", 32'(tx_valid), 0);
            check("vec_idle_txd", 32'(tx_data), 0);
            cyc();
            check("vec_grant", 32'(grant_id), 32'(vecs[i].exp_grant));
            check("vec_hdr", 32'(tx_data), 32'(8'hA0 | 8'(vecs[i].exp_grant)));
            check("vec_busy", 32'(busy), 1);
        end

        // Two-byte message from req0, then rr_ptr must prefer req1 over req0.
        do_reset();
        set_req(0, 1'b1, 8'h11, 1'b0);
        tx_ready = 1'b1;
        settle();
        check("m2_idle_txv", 32'(tx_valid), 0);
        cyc();
        check("m2_hdr", 32'(tx_data), 32'h0A0);
        check("m2_hdr_ready", 32'(req_ready), 0);
        cyc();
        check("m2_b0", 32'(tx_data), 32'h11);
        check("m2_b0_ready", 32'(req_ready), 32'b0001);
        set_req(0, 1'b1, 8'h22, 1'b1);
        settle();
        check("m2_b1", 32'(tx_data), 32'h22);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        settle();
        check("m2_busy_low", 32'(busy), 0);
        set_req(0, 1'b1, 8'h33, 1'b1);
        set_req(1, 1'b1, 8'h44, 1'b1);
        settle();
        cyc();
        check("m2_rr_grant", 32'(grant_id), 1);
        check("m2_rr_hdr", 32'(tx_data), 32'h0A1);

        // Header held while the transmitter back-pressures.
        do_reset();
        set_req(2, 1'b1, 8'h33, 1'b1);
        tx_ready = 1'b0;
        settle();
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("hold_hdr_data", 32'(tx_data), 32'h0A2);
            check("hold_hdr_valid", 32'(tx_valid), 1);
            check("hold_hdr_ready", 32'(req_ready), 0);
            cyc();
        end
        tx_ready = 1'b1;
        settle();
        check("hold_hdr_last", 32'(tx_data), 32'h0A2);
        cyc();
        check("hold_data", 32'(tx_data), 32'h33);
        check("hold_data_ready", 32'(req_ready), 32'b0100);
        cyc();
        check("hold_idle", 32'(busy), 0);

        // Stall timeout: req1 sends one byte, then goes silent.
        do_reset();
        tx_ready = 1'b1;
        set_req(1, 1'b1, 8'h55, 1'b0);
        settle();
        cyc();
        check("to_hdr", 32'(tx_data), 32'h0A1);
        cyc();
        check("to_byte", 32'(tx_data), 32'h55);
        cyc();
        set_req(1, 1'b0, 8'h00, 1'b1);
        for (int k = 0; k < TO; k++) begin
            settle();
            check("to_stall_pulse", 32'(timeout_pulse), 0);
            check("to_stall_busy", 32'(busy), 1);
            check("to_stall_txv", 32'(tx_valid), 0);
            cyc();
        end
        tx_ready = 1'b0;
        settle();
        check("to_pulse", 32'(timeout_pulse), 1);
        check("to_ff", 32'(tx_data), 32'h0FF);
        check("to_ff_valid", 32'(tx_valid), 1);
        check("to_ff_ready", 32'(req_ready), 0);
        cyc();
        check("to_pulse_once", 32'(timeout_pulse), 0);
        check("to_ff_held", 32'(tx_data), 32'h0FF);
        tx_ready = 1'b1;
        settle();
        cyc();
        check("to_idle", 32'(busy), 0);
        set_req(0, 1'b1, 8'h01, 1'b1);
        set_req(1, 1'b1, 8'h02, 1'b1);
        set_req(3, 1'b1, 8'h04, 1'b1);
        settle();
        cyc();
        check("to_next_grant", 32'(grant_id), 3);

        // Asynchronous reset in the middle of req3's message.
        do_reset();
        tx_ready = 1'b1;
        set_req(3, 1'b1, 8'hAA, 1'b0);
        settle();
        cyc();
        check("ar_hdr", 32'(tx_data), 32'h0A3);
        cyc();
        check("ar_b0", 32'(tx_data), 32'h0AA);
        set_req(3, 1'b1, 8'hBB, 1'b0);
        settle();
        check("ar_b1", 32'(tx_data), 32'h0BB);
        reset_n = 1'b0;
        settle();
        check_outputs_zero("ar_async");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        check("ar_idle_txv", 32'(tx_valid), 0);
        cyc();
        check("ar_restart_hdr", 32'(tx_data), 32'h0A3);
        check("ar_restart_grant", 32'(grant_id), 3);

        for (int rnd = 0; rnd < 3; rnd++)
            random_round();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
